// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution datapath front-end and calculator.
package conv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoadKernel,
    StStream,
    StFinish
  } conv_seq_state_t;

  // Default unpadded square resolutions, indexed by select code.
  localparam int unsigned NumXres = 5;
  localparam int unsigned XresDefault [NumXres] = '{4, 12, 20, 28, 36};

  // Side length of a square frame after adding a zero border of width pad on each side.
  function automatic int unsigned padded_res(input int unsigned xres, input int unsigned pad);
    return xres + 2 * pad;
  endfunction

endpackage

// File: rtl/conv_frame_counter.sv
// Walks (x, y) over a padded XS x XS frame, flags inside positions and counts pixel addresses.
module conv_frame_counter #(
  parameter int unsigned CntWidth  = 6,
  parameter int unsigned AddrWidth = 11,
  parameter int unsigned Pad       = 1
) (
  input  logic                 clock_i,
  input  logic                 clock_sreset_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [CntWidth-1:0]  xs_i,
  output logic                 last_o,
  output logic                 inside_o,
  output logic [AddrWidth-1:0] addr_o
);

  logic [CntWidth-1:0]  x_q, y_q;
  logic [AddrWidth-1:0] addr_q;
  logic [CntWidth-1:0]  edge_max;
  logic [CntWidth-1:0]  inner_lo;
  logic [CntWidth-1:0]  inner_hi;

  // Frame bounds derived from the latched padded side length.
  always_comb begin
    edge_max = xs_i - CntWidth'(1);
    inner_lo = CntWidth'(Pad);
    inner_hi = xs_i - CntWidth'(Pad) - CntWidth'(1);
    last_o   = (x_q == edge_max) && (y_q == edge_max);
    inside_o = (x_q >= inner_lo) && (x_q <= inner_hi) && (y_q >= inner_lo) && (y_q <= inner_hi);
    addr_o   = addr_q;
  end

  // x advances fastest; the address counter only moves on inside positions, so no multiply.
  always_ff @(posedge clock_i) begin
    if (clock_sreset_i || clear_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (en_i) begin
      if (x_q == edge_max) begin
        x_q <= '0;
        y_q <= (y_q == edge_max) ? '0 : y_q + CntWidth'(1);
      end else begin
        x_q <= x_q + CntWidth'(1);
      end
      if (inside_o) begin
        addr_q <= addr_q + AddrWidth'(1);
      end
    end
  end

endmodule

// File: rtl/conv_stream_sequencer.sv
// Loads one kernel then streams a zero-padded feature map into convolution_calc.
module conv_stream_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned XRES1       = XresDefault[0],
  parameter int unsigned XRES2       = XresDefault[1],
  parameter int unsigned XRES3       = XresDefault[2],
  parameter int unsigned XRES4       = XresDefault[3],
  parameter int unsigned XRES5       = XresDefault[4],
  parameter int unsigned RESOLUTIONS = 5,
  parameter int unsigned PAD         = 1,
  parameter int unsigned KX          = 3,
  parameter int unsigned KY          = 3,
  parameter int unsigned EXP         = 8,
  parameter int unsigned MANT        = 7,
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned KADDR_WIDTH = 4,
  localparam int unsigned WIDTH      = 1 + EXP + MANT
) (
  input  logic                   clock,
  input  logic                   clock_sreset,
  input  logic                   start,
  input  logic [2:0]             xres_select,
  output logic                   busy,
  output logic                   done,
  output logic                   kernel_rd_en,
  output logic [KADDR_WIDTH-1:0] kernel_rd_addr,
  input  logic [WIDTH-1:0]       kernel_rd_data,
  output logic                   pix_rd_en,
  output logic [ADDR_WIDTH-1:0]  pix_rd_addr,
  input  logic [WIDTH-1:0]       pix_rd_data,
  output logic                   kernel_valid,
  output logic [WIDTH-1:0]       kernel_data,
  output logic                   data_shift,
  output logic                   enable_calc,
  output logic [WIDTH-1:0]       data
);

  localparam int unsigned K        = KX * KY;
  localparam int unsigned CntWidth = $clog2(padded_res(XRES5, PAD) + 1);
  localparam int unsigned NumSel   = (RESOLUTIONS < NumXres) ? RESOLUTIONS : NumXres;
  localparam int unsigned MaxSel   = NumSel - 1;
  // Padded to 8 entries so every 3-bit code indexes a defined slot.
  localparam int unsigned XresTable [8] = '{XRES1, XRES2, XRES3, XRES4, XRES5,
                                            XRES5, XRES5, XRES5};

  conv_seq_state_t        state_q;
  logic [CntWidth-1:0]    xs_q;
  logic [KADDR_WIDTH-1:0] kcnt_q;
  logic                   kernel_valid_q;
  logic                   data_shift_q;
  logic                   enable_calc_q;
  logic                   done_q;

  logic [2:0]             sel_clamped;
  logic [CntWidth-1:0]    xs_sel;
  logic                   frame_clear;
  logic                   frame_en;
  logic                   frame_last;
  logic                   frame_inside;
  logic [ADDR_WIDTH-1:0]  frame_addr;

  // Clamp out-of-range resolution codes and derive the padded side length.
  always_comb begin
    sel_clamped = xres_select;
    if (32'(xres_select) > MaxSel) begin
      sel_clamped = 3'(MaxSel);
    end
    xs_sel = CntWidth'(padded_res(XresTable[sel_clamped], PAD));
  end

  assign frame_clear = (state_q == StIdle) && start;
  assign frame_en    = (state_q == StStream);

  conv_frame_counter #(
    .CntWidth  (CntWidth),
    .AddrWidth (ADDR_WIDTH),
    .Pad       (PAD)
  ) u_frame_counter (
    .clock_i        (clock),
    .clock_sreset_i (clock_sreset),
    .en_i           (frame_en),
    .clear_i        (frame_clear),
    .xs_i           (xs_q),
    .last_o         (frame_last),
    .inside_o       (frame_inside),
    .addr_o         (frame_addr)
  );

  // Sequencer FSM; stream controls are delayed one cycle to line up with read data.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      state_q        <= StIdle;
      xs_q           <= '0;
      kcnt_q         <= '0;
      kernel_valid_q <= 1'b0;
      data_shift_q   <= 1'b0;
      enable_calc_q  <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      kernel_valid_q <= (state_q == StLoadKernel);
      data_shift_q   <= (state_q == StStream);
      enable_calc_q  <= (state_q == StStream) && frame_inside;
      done_q         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            xs_q    <= xs_sel;
            kcnt_q  <= '0;
            state_q <= StLoadKernel;
          end
        end
        StLoadKernel: begin
          kcnt_q <= kcnt_q + KADDR_WIDTH'(1);
          if (kcnt_q == KADDR_WIDTH'(K - 1)) begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (frame_last) begin
            state_q <= StFinish;
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign kernel_rd_en   = (state_q == StLoadKernel);
  assign kernel_rd_addr = kcnt_q;
  assign pix_rd_en      = (state_q == StStream) && frame_inside;
  assign pix_rd_addr    = frame_addr;
  assign kernel_valid   = kernel_valid_q;
  assign kernel_data    = kernel_valid_q ? kernel_rd_data : '0;
  assign data_shift     = data_shift_q;
  assign enable_calc    = enable_calc_q;
  // Pad positions carry no read, so their data is forced to zero.
  assign data           = enable_calc_q ? pix_rd_data : '0;

endmodule
